// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// Packed time layout: {hour[5:0], minute[5:0], second[5:0], m_sec[6:0]}.
package stopwatch_pkg;

  localparam int unsigned TIME_W   = 25;
  localparam int unsigned MSEC_LSB = 0;
  localparam int unsigned SEC_LSB  = 7;
  localparam int unsigned MIN_LSB  = 13;
  localparam int unsigned HOUR_LSB = 19;

  typedef enum logic [2:0] {
    IDLE,
    RUNNING,
    LAP_HOLD,
    PAUSED,
    RECALL
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_lap_store.sv
// Lap register file: one synchronous write port, one combinational read port.
// Contents are not reset; validity is tracked by the controller's lap count.
module lap_store #(
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned TIME_W    = stopwatch_pkg::TIME_W,
  localparam int unsigned AW       = $clog2(LAP_DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [TIME_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [TIME_W-1:0] rdata
);
  import stopwatch_pkg::*;

  logic [TIME_W-1:0] mem_q [LAP_DEPTH];
  logic [TIME_W-1:0] mem_d [LAP_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edges to timer run/clear, lap capture,
// lap recall, and selection of the displayed time.
module stopwatch_ctrl #(
  parameter int unsigned LAP_DEPTH   = 8,
  parameter int unsigned HOLD_CYCLES = 150000000,
  parameter int unsigned TIME_W      = stopwatch_pkg::TIME_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              k_start_pause,
  input  logic              k_lap,
  input  logic              k_reset,
  input  logic              k_clear,
  input  logic [TIME_W-1:0] time_in,
  output logic              run_timer,
  output logic              reset_timer,
  output logic [TIME_W-1:0] disp_time,
  output logic [3:0]        lap_index,
  output logic [3:0]        lap_count,
  output logic              lap_full
);
  import stopwatch_pkg::*;

  localparam int unsigned AW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  state_e            state_q, state_d, ret_q, ret_d;
  logic [3:0]        prev_q, prev_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [TIME_W-1:0] hold_q, hold_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic              rst_pulse_q, rst_pulse_d;

  logic [3:0]        keys, edges;
  logic              e_sp, e_rst, e_lap, e_clr;
  logic              full, capture, we;
  logic [TIME_W-1:0] rd_data;

  lap_store #(
    .LAP_DEPTH (LAP_DEPTH),
    .TIME_W    (TIME_W)
  ) u_store (
    .clock (clock),
    .we    (we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (time_in),
    .raddr (rd_q),
    .rdata (rd_data)
  );

  always_comb begin
    keys   = {k_clear, k_lap, k_reset, k_start_pause};
    edges  = keys & ~prev_q;
    prev_d = keys;
    // One action per cycle: an edge is masked by any higher-priority edge,
    // even one the current state ignores.
    e_sp  = edges[0];
    e_rst = edges[1] & ~edges[0];
    e_lap = edges[2] & ~|edges[1:0];
    e_clr = edges[3] & ~|edges[2:0];

    full        = (cnt_q == CW'(LAP_DEPTH));
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    hold_d      = hold_q;
    hcnt_d      = hcnt_q;
    rst_pulse_d = 1'b0;
    capture     = 1'b0;
    we          = 1'b0;

    case (state_q)
      IDLE: begin
        if (e_sp) state_d = RUNNING;
        else if (e_lap && cnt_q != '0) begin
          state_d = RECALL;
          rd_d    = '0;
          ret_d   = IDLE;
        end else if (e_clr) begin
          cnt_d = '0;
          rd_d  = '0;
        end
      end
      RUNNING: begin
        if (e_sp)       state_d = PAUSED;
        else if (e_lap) capture = 1'b1;
      end
      LAP_HOLD: begin
        if (e_sp)                state_d = PAUSED;
        else if (e_lap)          capture = 1'b1;
        else if (hcnt_q == '0)   state_d = RUNNING;
        else                     hcnt_d  = hcnt_q - HW'(1);
      end
      PAUSED: begin
        if (e_sp) state_d = RUNNING;
        else if (e_rst) begin
          rst_pulse_d = 1'b1;
          state_d     = IDLE;
        end else if (e_lap && cnt_q != '0) begin
          state_d = RECALL;
          rd_d    = '0;
          ret_d   = PAUSED;
        end else if (e_clr) begin
          cnt_d = '0;
          rd_d  = '0;
        end
      end
      RECALL: begin
        if (e_sp) state_d = ret_q;
        else if (e_rst) begin
          rst_pulse_d = 1'b1;
          state_d     = IDLE;
        end else if (e_lap) begin
          if (CW'(rd_q) == cnt_q - CW'(1)) state_d = ret_q;
          else                             rd_d    = rd_q + AW'(1);
        end else if (e_clr) begin
          cnt_d   = '0;
          rd_d    = '0;
          state_d = ret_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      we      = ~full;
      cnt_d   = full ? cnt_q : cnt_q + CW'(1);
      hold_d  = time_in;
      hcnt_d  = HW'(HOLD_CYCLES - 1);
      state_d = LAP_HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      prev_q      <= '1;
      cnt_q       <= '0;
      rd_q        <= '0;
      hold_q      <= '0;
      hcnt_q      <= '0;
      rst_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      hold_q      <= hold_d;
      hcnt_q      <= hcnt_d;
      rst_pulse_q <= rst_pulse_d;
    end
  end

  always_comb begin
    run_timer = 1'b0;
    disp_time = time_in;
    lap_index = '0;
    case (state_q)
      RUNNING:  run_timer = 1'b1;
      LAP_HOLD: begin
        run_timer = 1'b1;
        disp_time = hold_q;
      end
      RECALL: begin
        disp_time = rd_data;
        lap_index = 4'(rd_q) + 4'd1;
      end
      default: ;
    endcase
  end

  assign reset_timer = reset | rst_pulse_q;
  assign lap_count   = 4'(cnt_q);
  assign lap_full    = full;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: vector table plus multi-cycle sequences.
module tb_stopwatch_ctrl;

  localparam int unsigned TW = 25;

  logic          clock = 1'b0;
  logic          reset;
  logic          k_start_pause, k_lap, k_reset, k_clear;
  logic [TW-1:0] time_in;
  logic          run_timer, reset_timer, lap_full;
  logic [TW-1:0] disp_time;
  logic [3:0]    lap_index, lap_count;

  int unsigned checks = 0;
  int unsigned passed = 0;

  typedef struct {
    logic          sp, lap, rst, clr;
    logic [TW-1:0] tin;
    logic          run, rt;
    logic [TW-1:0] disp;
    logic [3:0]    idx, cnt;
    logic          full;
  } vec_t;

  vec_t vecs[$];

  stopwatch_ctrl #(
    .LAP_DEPTH   (8),
    .HOLD_CYCLES (10),
    .TIME_W      (TW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .k_start_pause (k_start_pause),
    .k_lap         (k_lap),
    .k_reset       (k_reset),
    .k_clear       (k_clear),
    .time_in       (time_in),
    .run_timer     (run_timer),
    .reset_timer   (reset_timer),
    .disp_time     (disp_time),
    .lap_index     (lap_index),
    .lap_count     (lap_count),
    .lap_full      (lap_full)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step(input logic sp, input logic lap, input logic rst, input logic clr,
                      input logic [TW-1:0] tin);
    k_start_pause = sp;
    k_lap         = lap;
    k_reset       = rst;
    k_clear       = clr;
    time_in       = tin;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic run, input logic rt,
                         input logic [TW-1:0] disp, input logic [3:0] idx,
                         input logic [3:0] cnt, input logic full);
    chk({tag, "_run"},  32'(run_timer),   32'(run));
    chk({tag, "_rt"},   32'(reset_timer), 32'(rt));
    chk({tag, "_disp"}, 32'(disp_time),   32'(disp));
    chk({tag, "_idx"},  32'(lap_index),   32'(idx));
    chk({tag, "_cnt"},  32'(lap_count),   32'(cnt));
    chk({tag, "_full"}, 32'(lap_full),    32'(full));
  endtask

  task automatic add(input logic sp, input logic lap, input logic rst, input logic clr,
                     input logic [TW-1:0] tin, input logic run, input logic rt,
                     input logic [TW-1:0] disp, input logic [3:0] idx, input logic [3:0] cnt);
    vec_t v;
    v.sp = sp; v.lap = lap; v.rst = rst; v.clr = clr; v.tin = tin;
    v.run = run; v.rt = rt; v.disp = disp; v.idx = idx; v.cnt = cnt; v.full = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    logic [TW-1:0] exp_v;

    //  sp lap rst clr tin      run rt disp     idx cnt
    add(0, 0, 0, 0, 25'h100,  0, 0, 25'h100, 0, 0);  // idle
    add(1, 0, 0, 0, 25'h101,  1, 0, 25'h101, 0, 0);  // start
    add(0, 0, 0, 0, 25'h102,  1, 0, 25'h102, 0, 0);
    add(1, 0, 0, 0, 25'h103,  0, 0, 25'h103, 0, 0);  // pause
    add(0, 0, 0, 0, 25'h104,  0, 0, 25'h104, 0, 0);
    add(1, 0, 0, 0, 25'h110,  1, 0, 25'h110, 0, 0);  // resume
    add(0, 0, 0, 0, 25'h111,  1, 0, 25'h111, 0, 0);
    add(0, 1, 0, 0, 25'h00A,  1, 0, 25'h00A, 0, 1);  // lap A
    add(0, 0, 0, 0, 25'h200,  1, 0, 25'h00A, 0, 1);
    add(0, 1, 0, 0, 25'h00B,  1, 0, 25'h00B, 0, 2);  // lap B in hold
    add(0, 0, 0, 0, 25'h201,  1, 0, 25'h00B, 0, 2);
    add(0, 1, 0, 0, 25'h00C,  1, 0, 25'h00C, 0, 3);  // lap C
    add(0, 0, 0, 0, 25'h202,  1, 0, 25'h00C, 0, 3);
    add(1, 0, 0, 0, 25'h203,  0, 0, 25'h203, 0, 3);  // pause from hold
    add(0, 0, 0, 0, 25'h204,  0, 0, 25'h204, 0, 3);
    add(0, 1, 0, 0, 25'h205,  0, 0, 25'h00A, 1, 3);  // recall 1
    add(0, 0, 0, 0, 25'h205,  0, 0, 25'h00A, 1, 3);
    add(0, 1, 0, 0, 25'h205,  0, 0, 25'h00B, 2, 3);  // recall 2
    add(0, 0, 0, 0, 25'h205,  0, 0, 25'h00B, 2, 3);
    add(0, 1, 0, 0, 25'h205,  0, 0, 25'h00C, 3, 3);  // recall 3
    add(0, 0, 0, 0, 25'h205,  0, 0, 25'h00C, 3, 3);
    add(0, 1, 0, 0, 25'h206,  0, 0, 25'h206, 0, 3);  // back to paused
    add(0, 0, 0, 0, 25'h206,  0, 0, 25'h206, 0, 3);
    add(0, 0, 1, 0, 25'h207,  0, 1, 25'h207, 0, 3);  // timer zero pulse
    add(0, 0, 0, 0, 25'h208,  0, 0, 25'h208, 0, 3);
    add(0, 0, 0, 1, 25'h209,  0, 0, 25'h209, 0, 0);  // clear laps
    add(0, 0, 0, 0, 25'h20A,  0, 0, 25'h20A, 0, 0);
    add(0, 1, 0, 0, 25'h20B,  0, 0, 25'h20B, 0, 0);  // lap ignored, none stored
    add(0, 0, 0, 0, 25'h20C,  0, 0, 25'h20C, 0, 0);

    reset = 1'b1;
    step(0, 0, 0, 0, 25'h55);
    step(0, 0, 0, 0, 25'h56);
    chk_all("reset", 0, 1, 25'h56, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].sp, vecs[i].lap, vecs[i].rst, vecs[i].clr, vecs[i].tin);
      chk_all($sformatf("v%0d", i), vecs[i].run, vecs[i].rt, vecs[i].disp,
              vecs[i].idx, vecs[i].cnt, vecs[i].full);
    end

    // Lap hold duration.
    reset = 1'b1;
    step(0, 0, 0, 0, 25'h0);
    reset = 1'b0;
    step(0, 0, 0, 0, 25'h0);
    step(1, 0, 0, 0, 25'h1);
    step(0, 0, 0, 0, 25'h2);
    step(0, 1, 0, 0, 25'h0012345);
    chk_all("hold0", 1, 0, 25'h0012345, 0, 1, 0);
    for (int i = 1; i < 10; i++) begin
      step(0, 0, 0, 0, 25'(32'h100 + i));
      chk($sformatf("hold%0d_disp", i), 32'(disp_time), 32'h0012345);
    end
    step(0, 0, 0, 0, 25'h200);
    chk_all("hold_end", 1, 0, 25'h200, 0, 1, 0);

    // Fill the store and overflow it by one.
    for (int k = 2; k <= 9; k++) begin
      step(0, 1, 0, 0, 25'(32'h1000 + k));
      chk_all($sformatf("fill%0d", k), 1, 0, 25'(32'h1000 + k), 0,
              4'((k < 8) ? k : 8), (k >= 8));
      step(0, 0, 0, 0, 25'h3000);
    end
    step(1, 0, 0, 0, 25'h3001);
    step(0, 0, 0, 0, 25'h3002);
    for (int j = 1; j <= 8; j++) begin
      exp_v = (j == 1) ? 25'h0012345 : 25'(32'h1000 + j);
      step(0, 1, 0, 0, 25'h3003);
      chk_all($sformatf("rcl%0d", j), 0, 0, exp_v, 4'(j), 8, 1);
      step(0, 0, 0, 0, 25'h3003);
    end
    step(0, 1, 0, 0, 25'h400);
    chk_all("rcl_exit", 0, 0, 25'h400, 0, 8, 1);
    step(0, 0, 0, 0, 25'h400);

    // Simultaneous start/pause and lap: pause wins, nothing captured.
    step(0, 0, 0, 1, 25'h401);
    chk_all("clr_full", 0, 0, 25'h401, 0, 0, 0);
    step(0, 0, 0, 0, 25'h402);
    step(1, 0, 0, 0, 25'h403);
    chk("sim_run", 32'(run_timer), 32'd1);
    step(0, 0, 0, 0, 25'h404);
    step(1, 1, 0, 0, 25'h500);
    chk_all("sim_edge", 0, 0, 25'h500, 0, 0, 0);
    step(0, 0, 0, 0, 25'h501);

    // Keys held through reset release produce no action.
    k_start_pause = 1'b1;
    k_lap         = 1'b1;
    reset         = 1'b1;
    step(1, 1, 0, 0, 25'h600);
    step(1, 1, 0, 0, 25'h601);
    chk_all("hold_rst", 0, 1, 25'h601, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 25'(32'h610 + i));
      chk_all($sformatf("held%0d", i), 0, 0, 25'(32'h610 + i), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
